// File: rtl/pc_sequencer.sv
// Registered PC sequencer: sequential advance, relative branch, absolute jump and vector repeat.
// Optional build macro PCSEQ_ALIGN_CHK_EN rejects misaligned jump/branch targets instead of masking them.
module pc_sequencer #(
    parameter int                 WIDTH    = 16,
    parameter int                 STEP     = 2,
    parameter logic [WIDTH-1:0]   RESET_PC = '0,
    parameter int                 VLEN_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              jmp,
    input  logic [WIDTH-1:0]  jmp_tgt,
    input  logic              br_take,
    input  logic [WIDTH-1:0]  br_off,
    input  logic              vec_start,
    input  logic [VLEN_W-1:0] vec_len,
    output logic [WIDTH-1:0]  pc,
    output logic [VLEN_W-1:0] elem_idx,
    output logic              vec_busy,
    output logic              vec_done,
    output logic              misalign
);

    localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
    // STEP is a power of two, so STEP-1 covers exactly the alignment bits.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [VLEN_W-1:0] elem_idx_q, elem_idx_d;
    logic [VLEN_W-1:0] vlen_q, vlen_d;
    logic              vec_busy_q, vec_busy_d;
    logic              vec_done_q, vec_done_d;
    logic              misalign_q, misalign_d;

    logic [WIDTH-1:0]  seq_pc;
    logic [WIDTH-1:0]  tgt;

    always_comb begin
        pc_d       = pc_q;
        elem_idx_d = elem_idx_q;
        vlen_d     = vlen_q;
        vec_busy_d = vec_busy_q;
        vec_done_d = 1'b0;
        misalign_d = 1'b0;
        seq_pc     = pc_q + STEP_V;
        tgt        = jmp ? jmp_tgt : (pc_q + br_off);

        if (!stall) begin
            if (vec_busy_q) begin
                if (elem_idx_q < (vlen_q - VLEN_W'(1))) begin
                    elem_idx_d = elem_idx_q + VLEN_W'(1);
                end else begin
                    vec_busy_d = 1'b0;
                    elem_idx_d = '0;
                    vec_done_d = 1'b1;
                    pc_d       = seq_pc;
                end
            end else if (jmp || br_take) begin
`ifdef PCSEQ_ALIGN_CHK_EN
                if ((tgt & ALIGN_MASK) != '0) begin
                    pc_d       = seq_pc;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = tgt;
                end
`else
                pc_d = tgt & ~ALIGN_MASK;
`endif
            end else if (vec_start && (vec_len != '0)) begin
                vlen_d     = vec_len;
                vec_busy_d = 1'b1;
                elem_idx_d = '0;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            elem_idx_q <= '0;
            vlen_q     <= '0;
            vec_busy_q <= 1'b0;
            vec_done_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            elem_idx_q <= elem_idx_d;
            vlen_q     <= vlen_d;
            vec_busy_q <= vec_busy_d;
            vec_done_q <= vec_done_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign elem_idx = elem_idx_q;
    assign vec_busy = vec_busy_q;
    assign vec_done = vec_done_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jmp = 1'b0;
    logic [15:0] jmp_tgt = '0;
    logic        br_take = 1'b0;
    logic [15:0] br_off = '0;
    logic        vec_start = 1'b0;
    logic [7:0]  vec_len = '0;
    logic [15:0] pc;
    logic [7:0]  elem_idx;
    logic        vec_busy;
    logic        vec_done;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .jmp      (jmp),
        .jmp_tgt  (jmp_tgt),
        .br_take  (br_take),
        .br_off   (br_off),
        .vec_start(vec_start),
        .vec_len  (vec_len),
        .pc       (pc),
        .elem_idx (elem_idx),
        .vec_busy (vec_busy),
        .vec_done (vec_done),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; jmp = 1'b0; br_take = 1'b0; vec_start = 1'b0;
        jmp_tgt = '0; br_off = '0; vec_len = '0;
    endtask

    task automatic do_jump(input logic [15:0] t);
        jmp = 1'b1; jmp_tgt = t;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        checks++;
        if ({pc, elem_idx, vec_busy, vec_done, misalign} !== 27'd0) begin
            errors++;
            $display("FAIL reset_state pc=%h idx=%0d busy=%b done=%b mis=%b want all 0",
                     pc, elem_idx, vec_busy, vec_done, misalign);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (pc !== 16'(2 * i) || vec_busy !== 1'b0 || vec_done !== 1'b0 || misalign !== 1'b0) begin
                errors++;
                $display("FAIL seq_run[%0d] pc=%h busy=%b done=%b mis=%b want pc=%h flags 0",
                         i, pc, vec_busy, vec_done, misalign, 16'(2 * i));
            end
        end
    endtask

    task automatic test_jump_branch();
        do_jump(16'h0010);
        checks++;
        if (pc !== 16'h0010) begin errors++; $display("FAIL jmp_setup pc=%h want 0010", pc); end
        jmp = 1'b1; jmp_tgt = 16'h0100; br_take = 1'b1; br_off = 16'h0020;
        step();
        idle_inputs();
        checks++;
        if (pc !== 16'h0100) begin errors++; $display("FAIL jmp_over_br pc=%h want 0100", pc); end
        br_take = 1'b1; br_off = 16'hFFF0;
        step();
        idle_inputs();
        checks++;
        if (pc !== 16'h00F0) begin errors++; $display("FAIL br_neg pc=%h want 00f0", pc); end
        stall = 1'b1;
        step();
        stall = 1'b0;
        checks++;
        if (pc !== 16'h00F0) begin errors++; $display("FAIL stall_hold pc=%h want 00f0", pc); end
    endtask

    task automatic test_wrap();
        do_jump(16'hFFFE);
        step();
        checks++;
        if (pc !== 16'h0000) begin errors++; $display("FAIL seq_wrap pc=%h want 0000", pc); end
        do_jump(16'h0004);
        br_take = 1'b1; br_off = 16'hFFFA;
        step();
        idle_inputs();
        checks++;
        if (pc !== 16'hFFFE) begin errors++; $display("FAIL br_wrap pc=%h want fffe", pc); end
    endtask

    task automatic test_vector();
        do_jump(16'h0040);
        vec_start = 1'b1; vec_len = 8'd3;
        step();
        idle_inputs();
        checks++;
        if (pc !== 16'h0040 || elem_idx !== 8'd0 || vec_busy !== 1'b1) begin
            errors++; $display("FAIL vec_idx0 pc=%h idx=%0d busy=%b want 0040 0 1", pc, elem_idx, vec_busy);
        end
        jmp = 1'b1; jmp_tgt = 16'h0200;
        step();
        idle_inputs();
        checks++;
        if (pc !== 16'h0040 || elem_idx !== 8'd1 || vec_busy !== 1'b1) begin
            errors++; $display("FAIL vec_idx1_jmp_ignored pc=%h idx=%0d busy=%b want 0040 1 1", pc, elem_idx, vec_busy);
        end
        stall = 1'b1;
        step();
        stall = 1'b0;
        checks++;
        if (pc !== 16'h0040 || elem_idx !== 8'd1 || vec_busy !== 1'b1) begin
            errors++; $display("FAIL vec_stall pc=%h idx=%0d busy=%b want 0040 1 1", pc, elem_idx, vec_busy);
        end
        step();
        checks++;
        if (pc !== 16'h0040 || elem_idx !== 8'd2 || vec_busy !== 1'b1 || vec_done !== 1'b0) begin
            errors++; $display("FAIL vec_idx2 pc=%h idx=%0d busy=%b done=%b want 0040 2 1 0", pc, elem_idx, vec_busy, vec_done);
        end
        step();
        checks++;
        if (pc !== 16'h0042 || elem_idx !== 8'd0 || vec_busy !== 1'b0 || vec_done !== 1'b1) begin
            errors++; $display("FAIL vec_done pc=%h idx=%0d busy=%b done=%b want 0042 0 0 1", pc, elem_idx, vec_busy, vec_done);
        end
        vec_start = 1'b1; vec_len = 8'd0;
        step();
        idle_inputs();
        checks++;
        if (pc !== 16'h0044 || vec_busy !== 1'b0 || vec_done !== 1'b0) begin
            errors++; $display("FAIL vec_len0 pc=%h busy=%b done=%b want 0044 0 0", pc, vec_busy, vec_done);
        end
    endtask

    task automatic test_reset_mid_vector();
        do_jump(16'h0080);
        vec_start = 1'b1; vec_len = 8'd5;
        step();
        idle_inputs();
        step();
        step();
        checks++;
        if (elem_idx !== 8'd2 || vec_busy !== 1'b1) begin
            errors++; $display("FAIL rstv_idx2 idx=%0d busy=%b want 2 1", elem_idx, vec_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0000 || elem_idx !== 8'd0 || vec_busy !== 1'b0 || vec_done !== 1'b0) begin
            errors++; $display("FAIL rstv_async pc=%h idx=%0d busy=%b done=%b want 0000 0 0 0", pc, elem_idx, vec_busy, vec_done);
        end
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (pc !== 16'h0002 || vec_busy !== 1'b0 || vec_done !== 1'b0) begin
            errors++; $display("FAIL rstv_after pc=%h busy=%b done=%b want 0002 0 0", pc, vec_busy, vec_done);
        end
    endtask

    task automatic test_align();
        do_jump(16'h0010);
        jmp = 1'b1; jmp_tgt = 16'h0103;
        step();
        idle_inputs();
`ifdef PCSEQ_ALIGN_CHK_EN
        checks++;
        if (pc !== 16'h0012 || misalign !== 1'b1) begin
            errors++; $display("FAIL align_reject pc=%h mis=%b want 0012 1", pc, misalign);
        end
        step();
        checks++;
        if (pc !== 16'h0014 || misalign !== 1'b0) begin
            errors++; $display("FAIL align_pulse pc=%h mis=%b want 0014 0", pc, misalign);
        end
`else
        checks++;
        if (pc !== 16'h0102 || misalign !== 1'b0) begin
            errors++; $display("FAIL align_mask pc=%h mis=%b want 0102 0", pc, misalign);
        end
        step();
        checks++;
        if (pc !== 16'h0104 || misalign !== 1'b0) begin
            errors++; $display("FAIL align_after pc=%h mis=%b want 0104 0", pc, misalign);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_jump_branch();
        test_wrap();
        test_vector();
        test_reset_mid_vector();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
